// File: rtl/seg7_scan_ctrl_if.sv
// Host/display bundle for seg7_scan_ctrl: update strobe and masks in, scanned segment/anode drive out.
interface seg7_scan_ctrl_if;
    logic        I_load;
    logic [31:0] I_data;
    logic [7:0]  I_en;
    logic [7:0]  I_dp;
    logic [6:0]  O_seg;
    logic        O_dp;
    logic [7:0]  O_an;
    logic        O_busy;
    logic        O_frame;

    modport master (
        output I_load, I_data, I_en, I_dp,
        input  O_seg, O_dp, O_an, O_busy, O_frame
    );

    modport slave (
        input  I_load, I_data, I_en, I_dp,
        output O_seg, O_dp, O_an, O_busy, O_frame
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// 8-digit common-anode 7-segment scan controller with blank gaps and frame-synchronous updates.
// Optional leading-zero suppression is enabled by defining SEG7_LZ_BLANK_EN.
module seg7_scan_ctrl #(
    parameter int DIV_CNT   = 100000,
    parameter int BLANK_CNT = 1000
) (
    input logic             I_clk,
    input logic             I_rst,
    seg7_scan_ctrl_if.slave bus
);
    localparam int MAX_CNT = (DIV_CNT > BLANK_CNT) ? DIV_CNT : BLANK_CNT;
    localparam int CW      = $clog2(MAX_CNT + 1);
    localparam logic [CW-1:0] DIV_T   = CW'(DIV_CNT);
    localparam logic [CW-1:0] BLANK_T = CW'(BLANK_CNT);
    localparam logic [CW-1:0] ONE     = CW'(1);

    typedef enum logic {ST_BLANK, ST_SHOW} state_t;

    state_t        state, next_state;
    logic [CW-1:0] cnt, next_cnt;
    logic [2:0]    idx, next_idx;

    logic [31:0] act_data, pend_data;
    logic [7:0]  act_en, act_dp, pend_en, pend_dp;

    logic [7:0] an_q, an_next;
    logic [6:0] seg_q, seg_next;
    logic       dp_q, dp_next;
    logic       busy_q, frame_q, frame_next;
    logic       suppress, lit;

    function automatic logic [6:0] font(input logic [3:0] v);
        case (v)
            4'h0: font = 7'b1000000;
            4'h1: font = 7'b1111001;
            4'h2: font = 7'b0100100;
            4'h3: font = 7'b0110000;
            4'h4: font = 7'b0011001;
            4'h5: font = 7'b0010010;
            4'h6: font = 7'b0000010;
            4'h7: font = 7'b1111000;
            4'h8: font = 7'b0000000;
            4'h9: font = 7'b0010000;
            4'hA: font = 7'b0001000;
            4'hB: font = 7'b0000011;
            4'hC: font = 7'b1000110;
            4'hD: font = 7'b0100001;
            4'hE: font = 7'b0000110;
            default: font = 7'b0001110;
        endcase
    endfunction

    // Phase counter runs 1..terminal inside a phase; the reset value 0 adds the one
    // extra dark cycle so the first digit-0 SHOW lands at cycle BLANK_CNT+1.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        next_idx   = idx;
        case (state)
            ST_BLANK: begin
                if (cnt == BLANK_T) begin
                    next_state = ST_SHOW;
                    next_cnt   = ONE;
                end else begin
                    next_cnt = cnt + ONE;
                end
            end
            default: begin
                if (cnt == DIV_T) begin
                    next_idx   = idx + 3'd1;
                    next_state = (BLANK_CNT == 0) ? ST_SHOW : ST_BLANK;
                    next_cnt   = ONE;
                end else begin
                    next_cnt = cnt + ONE;
                end
            end
        endcase
    end

`ifdef SEG7_LZ_BLANK_EN
    assign suppress = (next_idx != 3'd0) && ((act_data >> {next_idx, 2'b00}) == 32'd0);
`else
    assign suppress = 1'b0;
`endif

    always_comb begin
        lit        = (next_state == ST_SHOW) && act_en[next_idx] && !suppress;
        an_next    = 8'hFF;
        seg_next   = 7'h7F;
        dp_next    = 1'b1;
        frame_next = (next_state == ST_SHOW) && (next_idx == 3'd7) && (next_cnt == DIV_T);
        if (lit) begin
            an_next  = ~(8'd1 << next_idx);
            seg_next = font(act_data[{next_idx, 2'b00} +: 4]);
            dp_next  = ~act_dp[next_idx];
        end
    end

    // A load seen while O_frame is high bypasses pending; otherwise the boundary copy
    // happens on the edge that raises O_frame, and a same-edge load still lands in pending.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state     <= ST_BLANK;
            cnt       <= '0;
            idx       <= 3'd0;
            act_data  <= '0;
            act_en    <= '0;
            act_dp    <= '0;
            pend_data <= '0;
            pend_en   <= '0;
            pend_dp   <= '0;
            busy_q    <= 1'b0;
            frame_q   <= 1'b0;
            an_q      <= 8'hFF;
            seg_q     <= 7'h7F;
            dp_q      <= 1'b1;
        end else begin
            state   <= next_state;
            cnt     <= next_cnt;
            idx     <= next_idx;
            frame_q <= frame_next;
            an_q    <= an_next;
            seg_q   <= seg_next;
            dp_q    <= dp_next;
            if (bus.I_load && frame_q) begin
                act_data <= bus.I_data;
                act_en   <= bus.I_en;
                act_dp   <= bus.I_dp;
                busy_q   <= 1'b0;
            end else begin
                if (frame_next && busy_q) begin
                    act_data <= pend_data;
                    act_en   <= pend_en;
                    act_dp   <= pend_dp;
                    busy_q   <= 1'b0;
                end
                if (bus.I_load) begin
                    pend_data <= bus.I_data;
                    pend_en   <= bus.I_en;
                    pend_dp   <= bus.I_dp;
                    busy_q    <= 1'b1;
                end
            end
        end
    end

    assign bus.O_an    = an_q;
    assign bus.O_seg   = seg_q;
    assign bus.O_dp    = dp_q;
    assign bus.O_busy  = busy_q;
    assign bus.O_frame = frame_q;
endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Time-multiplexed scan controller for the 8-digit common-anode 7-segment display on the lab board.
- Holds a 32-bit hex word (8 nibbles) with per-digit enable and decimal-point masks.
- Cycles one digit at a time with an anti-ghosting blank gap between digits.
- Applies host updates only at frame boundaries, so the display never tears mid-frame.
- Segment font is the team's standard hex font.

Parameters:
- DIV_CNT, 100000: clock cycles each digit is lit (SHOW phase); must be >= 1.
- BLANK_CNT, 1000: clock cycles all digits are dark before each digit (BLANK phase); 0 means the BLANK phase is skipped.

Ports:
- I_clk  input  1  system clock; all logic on the rising edge.
- I_rst  input  1  synchronous, active-high reset.
- I_load  input  1  one-cycle strobe; captures I_data/I_en/I_dp.
- I_data  input  32  hex digits; nibble k ([4k+3:4k]) drives digit k.
- I_en  input  8  digit enable mask; bit k=1 lights digit k.
- I_dp  input  8  decimal-point mask; bit k=1 lights the DP on digit k.
- O_seg  output  7  segments {g,f,e,d,c,b,a}, active low.
- O_dp  output  1  decimal point, active low.
- O_an  output  8  digit anodes, active low, one-hot or all-high.
- O_busy  output  1  update captured and pending, not yet displayed.
- O_frame  output  1  one-cycle pulse at each frame boundary.

Behaviour:
- Clock and reset: one clock, I_clk. I_rst is synchronous and active-high, sampled on the I_clk rising edge only.
- Reset values:
  - State BLANK, digit index 0, phase counter 0.
  - Active and pending data, enable and DP registers all 0.
  - O_an=8'hFF, O_seg=7'h7F, O_dp=1, O_busy=0, O_frame=0.
- Reset asserted mid-frame: the same values are forced on the next edge and any pending update is discarded.
- FSM states:
  - BLANK: O_an=8'hFF, O_seg=7'h7F, O_dp=1. Lasts BLANK_CNT cycles, then goes to SHOW with the same index.
  - SHOW: lasts DIV_CNT cycles, then the index advances (mod 8) and the FSM goes to BLANK. If BLANK_CNT=0 it goes straight to SHOW for the next index.
- SHOW outputs for digit k:
  - If active en[k]=1: O_an = all ones except bit k = 0; O_seg = font(nibble k); O_dp = ~dp[k].
  - If en[k]=0: O_an=8'hFF, O_seg=7'h7F, O_dp=1. The timeslot is still consumed.
- Output registration: outputs are registered from next-state values, so each phase's outputs are stable for exactly that phase's cycle count. There is no glitch at phase change.
- Frame period is 8*(DIV_CNT+BLANK_CNT) cycles. The first digit-0 SHOW after reset starts at cycle BLANK_CNT+1.
- Font, hex 0..F in the order 0,1,2,...,F:
  - 1000000, 1111001, 0100100, 0110000
  - 0011001, 0010010, 0000010, 1111000
  - 0000000, 0010000, 0001000, 0000011
  - 1000110, 0100001, 0000110, 0001110
- Update handshake:
  - I_load=1 copies I_data/I_en/I_dp into the pending registers and sets O_busy=1 on the next cycle.
  - A new I_load while busy overwrites pending (last write wins).
- Frame boundary: the cycle in which the index wraps 7->0 at the end of digit 7's SHOW.
  - O_frame pulses for that cycle.
  - If busy, pending is copied to active and O_busy clears.
- Load on the boundary cycle: the values on I_data/I_en/I_dp bypass pending, go straight to active, and O_busy stays/returns 0.
- Counters: phase counter width is $clog2(max(DIV_CNT,BLANK_CNT)+1). No counter ever exceeds its terminal count. The index is a 3-bit wrap counter.

Optional Feature:
SEG7_LZ_BLANK_EN (leading-zero suppression).
- Defined: digit k is additionally blanked when nibble k is 0 and all higher nibbles are 0.
  - Digit 0 is never suppressed.
  - Suppression uses the active register and is evaluated per SHOW phase.
  - A suppressed digit behaves exactly like en[k]=0 (anode off, O_dp=1).
- Undefined: zeros display normally; the feature logic is absent.

Test Plan (DIV_CNT=4, BLANK_CNT=2 unless noted):
1. Reset, then I_load with data=32'h76543210, en=8'hFF, dp=8'h00 -> O_busy=1 until the first O_frame, which occurs 48 cycles after reset release. Next frame: each digit k shows O_an=~(1<<k) for 4 cycles with font(k), e.g. digit 2 O_seg=0100100; 2 dark cycles between digits.
2. data=32'hFEDCBA98, en=8'b0000_0101, dp=8'h04 -> only O_an=8'hFE (O_seg=0000000) and 8'hFB (O_seg=0001000, O_dp=0) ever low; all other slots fully dark; frame still 48 cycles.
3. Two loads mid-frame (32'h11111111 then 32'h22222222) -> current frame unchanged; next frame shows all 2s (O_seg=0100100); O_busy falls in the O_frame cycle.
4. I_load coincident with O_frame -> new data visible from the following digit-0 SHOW; O_busy never rises.
5. I_rst pulsed during digit 5 SHOW with a load pending -> next edge O_an=8'hFF, O_busy=0; old active data not shown (all en=0) until the next load plus boundary.
6. SEG7_LZ_BLANK_EN defined, data=32'h00000A05, en=8'hFF -> only digits 0..2 light (5, 0, A); the digit-1 zero is shown; digits 3..7 dark. BLANK_CNT=0 run -> no dark gap, frame=32 cycles.
